// File: rtl/cluster_pkg.sv
// Shared cluster-word definitions for the cluster packer and unpacker.
// Holds geometry, the empty-slot sentinel and the on-wire cluster word layout.
package cluster_pkg;

  localparam int NUM_SBITS    = 1536;
  localparam int ADR_W        = 11;
  localparam int CNT_W        = 3;
  localparam int MAX_CLUSTERS = 8;
  localparam int ERR_CNT_W    = 8;
  localparam int NCL_W        = 4;

  localparam logic [ADR_W-1:0] INVALID_ADR = 11'h7FF;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [ADR_W-1:0] adr;
  } cluster_word_t;

  typedef enum logic {
    IDLE,
    ACCUM
  } unpack_state_e;

  // The sentinel is already out of range; it is named here so both sides agree on it.
  function automatic logic adr_in_range(input logic [ADR_W-1:0] adr);
    return (adr != INVALID_ADR) && (adr < ADR_W'(NUM_SBITS));
  endfunction

endpackage

// File: rtl/cluster_mask_gen.sv
// Combinational expansion of one cluster word into a NUM_SBITS-wide strip mask.
// Out-of-range addresses yield an empty mask; strips past the top edge are dropped.
module cluster_mask_gen
  import cluster_pkg::*;
(
  input  logic [ADR_W-1:0]     adr_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic                 adr_valid_o,
  output logic [NUM_SBITS-1:0] mask_o
);

  logic [NUM_SBITS-1:0] run;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    run = '0;
    for (int j = 0; j < (1 << CNT_W); j++) begin
      run[j] = (j <= int'(cnt_i));
    end
    adr_valid_o = adr_in_range(adr_i);
    // A plain left shift discards bits beyond the top strip, so nothing wraps to bit 0.
    mask_o = adr_valid_o ? (run << adr_i) : '0;
  end

endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the S-bit hit map from a framed stream of cluster words at clock4x.
// Emits one registered map per frame and flags framing errors and cluster overflow.
module cluster_unpacker
  import cluster_pkg::*;
(
  input  logic                 clock4x,
  input  logic                 global_reset_n,
  input  logic                 clst_valid,
  input  logic                 clst_sof,
  input  logic                 clst_eof,
  input  logic [ADR_W-1:0]     clst_adr,
  input  logic [CNT_W-1:0]     clst_cnt,
  output logic [NUM_SBITS-1:0] vpfs_out,
  output logic                 vpfs_valid,
  output logic [NCL_W-1:0]     nclusters,
  output logic                 overflow,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  cluster_word_t        word;
  logic [NUM_SBITS-1:0] mask;
  logic                 mask_valid;
  logic [NCL_W-1:0]     word_cnt;

  unpack_state_e        state_q, state_d;
  logic [NUM_SBITS-1:0] acc_q, acc_d;
  logic [NCL_W-1:0]     ncl_q, ncl_d;
  logic                 ovf_q, ovf_d;
  logic                 pend_q, pend_d;

  logic                 emit;
  logic [NUM_SBITS-1:0] emit_acc;
  logic [NCL_W-1:0]     emit_ncl;
  logic                 emit_ovf;
  logic                 err;

  logic [NUM_SBITS-1:0] vpfs_q;
  logic                 vpfs_valid_q;
  logic [NCL_W-1:0]     nclusters_q;
  logic                 overflow_q;
  logic                 err_pulse_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign word     = '{cnt: clst_cnt, adr: clst_adr};
  assign word_cnt = NCL_W'(mask_valid);

  cluster_mask_gen u_mask_gen (
    .adr_i       (word.adr),
    .cnt_i       (word.cnt),
    .adr_valid_o (mask_valid),
    .mask_o      (mask)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ncl_d    = ncl_q;
    ovf_d    = ovf_q;
    pend_d   = 1'b0;
    emit     = 1'b0;
    emit_acc = acc_q;
    emit_ncl = ncl_q;
    emit_ovf = ovf_q;
    err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A frame that closed together with a sof-in-ACCUM leaves here one cycle later.
        emit = pend_q;
        if (clst_valid) begin
          if (clst_sof) begin
            acc_d = mask;
            ncl_d = word_cnt;
            ovf_d = 1'b0;
            if (!clst_eof) begin
              state_d = ACCUM;
            end else if (pend_q) begin
              pend_d = 1'b1;
            end else begin
              emit     = 1'b1;
              emit_acc = mask;
              emit_ncl = word_cnt;
              emit_ovf = 1'b0;
            end
          end else begin
            err = 1'b1;
          end
        end
      end

      ACCUM: begin
        if (clst_valid) begin
          if (clst_sof) begin
            emit  = 1'b1;
            err   = 1'b1;
            acc_d = mask;
            ncl_d = word_cnt;
            ovf_d = 1'b0;
            if (clst_eof) begin
              pend_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            if (ncl_q < NCL_W'(MAX_CLUSTERS)) begin
              if (mask_valid) begin
                acc_d = acc_q | mask;
                ncl_d = ncl_q + NCL_W'(1);
              end
            end else begin
              ovf_d = 1'b1;
            end
            if (clst_eof) begin
              emit     = 1'b1;
              emit_acc = acc_d;
              emit_ncl = ncl_d;
              emit_ovf = ovf_d;
              state_d  = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the wide accumulator and map are flops, not RAM, so they take the async reset like any register.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ncl_q        <= '0;
      ovf_q        <= 1'b0;
      pend_q       <= 1'b0;
      vpfs_q       <= '0;
      vpfs_valid_q <= 1'b0;
      nclusters_q  <= '0;
      overflow_q   <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q      <= state_d;
      acc_q        <= acc_d;
      ncl_q        <= ncl_d;
      ovf_q        <= ovf_d;
      pend_q       <= pend_d;
      vpfs_valid_q <= emit;
      overflow_q   <= emit & emit_ovf;
      err_pulse_q  <= err;
      if (emit) begin
        vpfs_q      <= emit_acc;
        nclusters_q <= emit_ncl;
      end
      if (err && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign vpfs_out   = vpfs_q;
  assign vpfs_valid = vpfs_valid_q;
  assign nclusters  = nclusters_q;
  assign overflow   = overflow_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_cluster_unpacker.sv
// Directed self-checking bench for cluster_unpacker: framing, edges, errors, reset.
// Inputs change 1 time unit after posedge; outputs are sampled on the negedge.
module tb_cluster_unpacker;

  logic          clock4x;
  logic          global_reset_n;
  logic          clst_valid;
  logic          clst_sof;
  logic          clst_eof;
  logic [10:0]   clst_adr;
  logic [2:0]    clst_cnt;
  logic [1535:0] vpfs_out;
  logic          vpfs_valid;
  logic [3:0]    nclusters;
  logic          overflow;
  logic          err_pulse;
  logic [7:0]    err_cnt;

  int            errors = 0;
  int            checks = 0;
  logic [1535:0] exp_map;

  cluster_unpacker dut (
    .clock4x        (clock4x),
    .global_reset_n (global_reset_n),
    .clst_valid     (clst_valid),
    .clst_sof       (clst_sof),
    .clst_eof       (clst_eof),
    .clst_adr       (clst_adr),
    .clst_cnt       (clst_cnt),
    .vpfs_out       (vpfs_out),
    .vpfs_valid     (vpfs_valid),
    .nclusters      (nclusters),
    .overflow       (overflow),
    .err_pulse      (err_pulse),
    .err_cnt        (err_cnt)
  );

  initial clock4x = 1'b0;
  always #3 clock4x = ~clock4x;

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [10:0] a, input logic [2:0] c);
    @(posedge clock4x);
    #1;
    clst_valid = v;
    clst_sof   = s;
    clst_eof   = e;
    clst_adr   = a;
    clst_cnt   = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 11'd0, 3'd0);
  endtask

  task automatic sample();
    @(negedge clock4x);
  endtask

  task automatic test_reset();
    global_reset_n = 1'b0;
    clst_valid = 1'b0; clst_sof = 1'b0; clst_eof = 1'b0; clst_adr = '0; clst_cnt = '0;
    repeat (3) @(posedge clock4x);
    sample();
    checks++;
    if (vpfs_out !== '0) begin errors++; $display("FAIL reset_map: got ones=%0d want 0", $countones(vpfs_out)); end
    checks++;
    if ({vpfs_valid, overflow, err_pulse} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {vpfs_valid, overflow, err_pulse});
    end
    checks++;
    if ({nclusters, err_cnt} !== 12'h000) begin
      errors++; $display("FAIL reset_counts: got ncl=%0d err_cnt=%0d want 0 0", nclusters, err_cnt);
    end
    global_reset_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 1'b1, 11'd10, 3'd2);
    idle();
    sample();
    exp_map = '0; exp_map[10] = 1'b1; exp_map[11] = 1'b1; exp_map[12] = 1'b1;
    checks++;
    if (vpfs_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", vpfs_valid); end
    checks++;
    if (vpfs_out !== exp_map) begin errors++; $display("FAIL single_map: got ones=%0d want ones=3 (10..12)", $countones(vpfs_out)); end
    checks++;
    if (nclusters !== 4'd1) begin errors++; $display("FAIL single_ncl: got %0d want 1", nclusters); end
    idle();
    sample();
    checks++;
    if (vpfs_valid !== 1'b0 || vpfs_out !== exp_map) begin
      errors++; $display("FAIL single_hold: got valid=%b ones=%0d want valid=0 ones=3", vpfs_valid, $countones(vpfs_out));
    end
  endtask

  task automatic test_full_frame();
    exp_map = '0;
    for (int k = 0; k < 8; k++) begin
      exp_map[k*100] = 1'b1;
      drive(1'b1, k == 0, k == 7, 11'(k*100), 3'd0);
    end
    idle();
    sample();
    checks++;
    if (vpfs_valid !== 1'b1 || vpfs_out !== exp_map) begin
      errors++; $display("FAIL full8_map: got valid=%b ones=%0d want valid=1 ones=8", vpfs_valid, $countones(vpfs_out));
    end
    checks++;
    if (nclusters !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL full8_count: got ncl=%0d ovf=%b want 8 0", nclusters, overflow);
    end
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, k == 0, k == 8, 11'(k*100), 3'd0);
    end
    idle();
    sample();
    checks++;
    if (vpfs_valid !== 1'b1 || vpfs_out !== exp_map || vpfs_out[800] !== 1'b0) begin
      errors++; $display("FAIL full9_map: got valid=%b ones=%0d bit800=%b want 1 8 0", vpfs_valid, $countones(vpfs_out), vpfs_out[800]);
    end
    checks++;
    if (nclusters !== 4'd8 || overflow !== 1'b1) begin
      errors++; $display("FAIL full9_ovf: got ncl=%0d ovf=%b want 8 1", nclusters, overflow);
    end
    idle();
    sample();
    checks++;
    if (overflow !== 1'b0 || vpfs_valid !== 1'b0) begin
      errors++; $display("FAIL full9_pulse: got ovf=%b valid=%b want 0 0", overflow, vpfs_valid);
    end
  endtask

  task automatic test_edges();
    drive(1'b1, 1'b1, 1'b1, 11'd1534, 3'd7);
    idle();
    sample();
    exp_map = '0; exp_map[1534] = 1'b1; exp_map[1535] = 1'b1;
    checks++;
    if (vpfs_out !== exp_map || vpfs_out[0] !== 1'b0) begin
      errors++; $display("FAIL edge_trunc: got ones=%0d bit0=%b want ones=2 bit0=0", $countones(vpfs_out), vpfs_out[0]);
    end
    checks++;
    if (nclusters !== 4'd1) begin errors++; $display("FAIL edge_ncl: got %0d want 1", nclusters); end

    drive(1'b1, 1'b1, 1'b0, 11'd5, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 11'h7FF, 3'd3);
    drive(1'b1, 1'b0, 1'b1, 11'd20, 3'd1);
    idle();
    sample();
    exp_map = '0; exp_map[5] = 1'b1; exp_map[20] = 1'b1; exp_map[21] = 1'b1;
    checks++;
    if (vpfs_out !== exp_map || nclusters !== 4'd2) begin
      errors++; $display("FAIL sentinel_map: got ones=%0d ncl=%0d want ones=3 ncl=2", $countones(vpfs_out), nclusters);
    end
    checks++;
    if (err_pulse !== 1'b0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL sentinel_err: got pulse=%b cnt=%0d want 0 0", err_pulse, err_cnt);
    end

    drive(1'b1, 1'b1, 1'b1, 11'd1600, 3'd2);
    idle();
    sample();
    checks++;
    if (vpfs_valid !== 1'b1 || vpfs_out !== '0 || nclusters !== 4'd0) begin
      errors++; $display("FAIL range_empty: got valid=%b ones=%0d ncl=%0d want 1 0 0", vpfs_valid, $countones(vpfs_out), nclusters);
    end
  endtask

  task automatic test_protocol();
    drive(1'b1, 1'b0, 1'b0, 11'd30, 3'd0);
    idle();
    sample();
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || vpfs_valid !== 1'b0) begin
      errors++; $display("FAIL nosof_err: got pulse=%b cnt=%0d valid=%b want 1 1 0", err_pulse, err_cnt, vpfs_valid);
    end

    drive(1'b1, 1'b1, 1'b0, 11'd40, 3'd1);
    drive(1'b1, 1'b0, 1'b0, 11'd50, 3'd0);
    drive(1'b1, 1'b1, 1'b0, 11'd60, 3'd0);
    drive(1'b1, 1'b0, 1'b1, 11'd61, 3'd0);
    sample();
    exp_map = '0; exp_map[40] = 1'b1; exp_map[41] = 1'b1; exp_map[50] = 1'b1;
    checks++;
    if (vpfs_valid !== 1'b1 || vpfs_out !== exp_map || nclusters !== 4'd2) begin
      errors++; $display("FAIL sofaccum_prior: got valid=%b ones=%0d ncl=%0d want 1 3 2", vpfs_valid, $countones(vpfs_out), nclusters);
    end
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL sofaccum_err: got pulse=%b cnt=%0d want 1 2", err_pulse, err_cnt);
    end
    idle();
    sample();
    exp_map = '0; exp_map[60] = 1'b1; exp_map[61] = 1'b1;
    checks++;
    if (vpfs_valid !== 1'b1 || vpfs_out !== exp_map || nclusters !== 4'd2 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL sofaccum_new: got valid=%b ones=%0d ncl=%0d err=%b want 1 2 2 0", vpfs_valid, $countones(vpfs_out), nclusters, err_pulse);
    end

    drive(1'b1, 1'b1, 1'b0, 11'd70, 3'd0);
    drive(1'b1, 1'b1, 1'b1, 11'd80, 3'd0);
    idle();
    sample();
    exp_map = '0; exp_map[70] = 1'b1;
    checks++;
    if (vpfs_valid !== 1'b1 || vpfs_out !== exp_map || err_cnt !== 8'd3) begin
      errors++; $display("FAIL sofeof_first: got valid=%b ones=%0d bit70=%b cnt=%0d want 1 1 1 3", vpfs_valid, $countones(vpfs_out), vpfs_out[70], err_cnt);
    end
    idle();
    sample();
    exp_map = '0; exp_map[80] = 1'b1;
    checks++;
    if (vpfs_valid !== 1'b1 || vpfs_out !== exp_map || nclusters !== 4'd1) begin
      errors++; $display("FAIL sofeof_second: got valid=%b ones=%0d bit80=%b ncl=%0d want 1 1 1 1", vpfs_valid, $countones(vpfs_out), vpfs_out[80], nclusters);
    end
    idle();
    sample();
    checks++;
    if (vpfs_valid !== 1'b0) begin errors++; $display("FAIL sofeof_quiet: got valid=%b want 0", vpfs_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1535:0] exp_a;
    exp_a = '0;
    exp_map = '0;
    for (int k = 0; k < 4; k++) begin
      exp_a[k*10] = 1'b1;
      exp_map[k*10+1] = 1'b1;
      exp_map[k*10+2] = 1'b1;
      drive(1'b1, k == 0, k == 3, 11'(k*10), 3'd0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k == 0, k == 3, 11'(k*10+1), 3'd1);
      sample();
      if (k == 0) begin
        checks++;
        if (vpfs_valid !== 1'b1 || vpfs_out !== exp_a || nclusters !== 4'd4) begin
          errors++; $display("FAIL b2b_first: got valid=%b ones=%0d ncl=%0d want 1 4 4", vpfs_valid, $countones(vpfs_out), nclusters);
        end
      end else begin
        checks++;
        if (vpfs_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: got valid=%b want 0", k, vpfs_valid); end
      end
    end
    idle();
    sample();
    checks++;
    if (vpfs_valid !== 1'b1 || vpfs_out !== exp_map || nclusters !== 4'd4) begin
      errors++; $display("FAIL b2b_second: got valid=%b ones=%0d ncl=%0d want 1 8 4", vpfs_valid, $countones(vpfs_out), nclusters);
    end
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 1'b1, 1'b0, 11'd200, 3'd3);
    drive(1'b1, 1'b0, 1'b0, 11'd300, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 11'd400, 3'd0);
    idle();
    #1 global_reset_n = 1'b0;
    #1;
    checks++;
    if (vpfs_out !== '0 || err_cnt !== 8'd0 || nclusters !== 4'd0 || vpfs_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_clear: got ones=%0d cnt=%0d ncl=%0d valid=%b want 0 0 0 0", $countones(vpfs_out), err_cnt, nclusters, vpfs_valid);
    end
    @(posedge clock4x);
    sample();
    global_reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 11'd500, 3'd0);
    drive(1'b1, 1'b1, 1'b0, 11'd900, 3'd0);
    drive(1'b1, 1'b0, 1'b1, 11'd901, 3'd0);
    idle();
    sample();
    exp_map = '0; exp_map[900] = 1'b1; exp_map[901] = 1'b1;
    checks++;
    if (vpfs_valid !== 1'b1 || vpfs_out !== exp_map || nclusters !== 4'd2) begin
      errors++; $display("FAIL midreset_fresh: got valid=%b ones=%0d ncl=%0d want 1 2 2", vpfs_valid, $countones(vpfs_out), nclusters);
    end
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL midreset_err: got cnt=%0d want 1", err_cnt); end
  endtask

  task automatic test_err_saturation();
    for (int k = 0; k < 253; k++) drive(1'b1, 1'b0, 1'b0, 11'd5, 3'd0);
    idle();
    sample();
    checks++;
    if (err_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", err_cnt); end
    for (int k = 0; k < 46; k++) drive(1'b1, 1'b0, 1'b0, 11'd5, 3'd0);
    idle();
    sample();
    checks++;
    if (err_cnt !== 8'd255 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL sat_255: got cnt=%0d pulse=%b want 255 1", err_cnt, err_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_frame();
    test_edges();
    test_protocol();
    test_back_to_back();
    test_reset_mid_frame();
    test_err_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
